idu_pipe: RTL

Pipelined, parametrised successor to the IDU_top instruction decode unit. It accepts RV32I instruction words with their PC over a valid/ready handshake and buffers them in a small input FIFO. Each instruction is decoded in one stage, and the decoded operation is presented to the CU at up to one instruction per cycle, replacing the fixed 4-cycle receive/decode sequence. Unused register and immediate fields are qualified by enable bits instead of being driven to Z.

---
 rtl/idu_pkg.sv | 81 ++++++++
 rtl/idu_decode_comb.sv | 162 ++++++++++++++++
 rtl/idu_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/idu_pkg.sv
// idu_pkg: CU opcodes, RV32 major opcodes and the decoded-instruction record shared by idu_pipe
package idu_pkg;

   localparam logic [5:0] OP_LUI     = 6'd0;
   localparam logic [5:0] OP_AUIPC   = 6'd1;
   localparam logic [5:0] OP_JAL     = 6'd2;
   localparam logic [5:0] OP_JALR    = 6'd3;
   localparam logic [5:0] OP_BEQ     = 6'd4;
   localparam logic [5:0] OP_BNE     = 6'd5;
   localparam logic [5:0] OP_BLT     = 6'd6;
   localparam logic [5:0] OP_BGE     = 6'd7;
   localparam logic [5:0] OP_BLTU    = 6'd8;
   localparam logic [5:0] OP_BGEU    = 6'd9;
   localparam logic [5:0] OP_SB      = 6'd10;
   localparam logic [5:0] OP_SH      = 6'd11;
   localparam logic [5:0] OP_SW      = 6'd12;
   localparam logic [5:0] OP_LB      = 6'd13;
   localparam logic [5:0] OP_LH      = 6'd14;
   localparam logic [5:0] OP_LW      = 6'd15;
   localparam logic [5:0] OP_LBU     = 6'd16;
   localparam logic [5:0] OP_LHU     = 6'd17;
   localparam logic [5:0] OP_ADDI    = 6'd18;
   localparam logic [5:0] OP_SLTI    = 6'd19;
   localparam logic [5:0] OP_SLTIU   = 6'd20;
   localparam logic [5:0] OP_XORI    = 6'd21;
   localparam logic [5:0] OP_ORI     = 6'd22;
   localparam logic [5:0] OP_ANDI    = 6'd23;
   localparam logic [5:0] OP_SLLI    = 6'd24;
   localparam logic [5:0] OP_SRLI    = 6'd25;
   localparam logic [5:0] OP_SRAI    = 6'd26;
   localparam logic [5:0] OP_ADD     = 6'd27;
   localparam logic [5:0] OP_SUB     = 6'd28;
   localparam logic [5:0] OP_SLL     = 6'd29;
   localparam logic [5:0] OP_SLT     = 6'd30;
   localparam logic [5:0] OP_SLTU    = 6'd31;
   localparam logic [5:0] OP_XOR     = 6'd32;
   localparam logic [5:0] OP_SRL     = 6'd33;
   localparam logic [5:0] OP_SRA     = 6'd34;
   localparam logic [5:0] OP_OR      = 6'd35;
   localparam logic [5:0] OP_AND     = 6'd36;
   localparam logic [5:0] OP_FENCE   = 6'd37;
   localparam logic [5:0] OP_FENCEI  = 6'd38;
   localparam logic [5:0] OP_ECALL   = 6'd39;
   localparam logic [5:0] OP_EBREAK  = 6'd40;
   localparam logic [5:0] OP_MUL     = 6'd41;
   localparam logic [5:0] OP_MULH    = 6'd42;
   localparam logic [5:0] OP_MULHSU  = 6'd43;
   localparam logic [5:0] OP_MULHU   = 6'd44;
   localparam logic [5:0] OP_DIV     = 6'd45;
   localparam logic [5:0] OP_DIVU    = 6'd46;
   localparam logic [5:0] OP_REM     = 6'd47;
   localparam logic [5:0] OP_REMU    = 6'd48;
   localparam logic [5:0] OP_INVALID = 6'd63;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rd_en;
      logic        rs1_en;
      logic        rs2_en;
      logic        imm_en;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic        invalid;
   } idu_dec_t;

endpackage

// File: rtl/idu_decode_comb.sv
// idu_decode_comb: combinational RV32I (+M when IDU_PIPE_RV32M_EN) word to idu_dec_t decoder
module idu_decode_comb
   import idu_pkg::*;
(
   input  logic [31:0] instr,
   output idu_dec_t    dec
);

`ifdef IDU_PIPE_RV32M_EN
   localparam logic HAS_M = 1'b1;
`else
   localparam logic HAS_M = 1'b0;
`endif

   logic [6:0]  opc;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic [5:0]  op;
   logic [3:0]  en;
   logic [4:0]  shamt;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // classify the word; en = {rd, rs1, rs2, imm} marks which fields the op uses
   always_comb begin
      op    = OP_INVALID;
      en    = 4'b0000;
      imm   = imm_i;
      shamt = 5'd0;
      case (opc)
         OPC_LUI: begin
            op  = OP_LUI;
            en  = 4'b1001;
            imm = imm_u;
         end
         OPC_AUIPC: begin
            op  = OP_AUIPC;
            en  = 4'b1001;
            imm = imm_u;
         end
         OPC_JAL: begin
            op  = OP_JAL;
            en  = 4'b1001;
            imm = imm_j;
         end
         OPC_JALR: begin
            op = f3 == 3'b000 ? OP_JALR : OP_INVALID;
            en = 4'b1101;
         end
         OPC_BRANCH: begin
            en  = 4'b0111;
            imm = imm_b;
            case (f3)
               3'b000:  op = OP_BEQ;
               3'b001:  op = OP_BNE;
               3'b100:  op = OP_BLT;
               3'b101:  op = OP_BGE;
               3'b110:  op = OP_BLTU;
               3'b111:  op = OP_BGEU;
               default: op = OP_INVALID;
            endcase
         end
         OPC_STORE: begin
            en  = 4'b0111;
            imm = imm_s;
            op  = f3 == 3'b000 ? OP_SB : f3 == 3'b001 ? OP_SH : f3 == 3'b010 ? OP_SW : OP_INVALID;
         end
         OPC_LOAD: begin
            en = 4'b1101;
            case (f3)
               3'b000:  op = OP_LB;
               3'b001:  op = OP_LH;
               3'b010:  op = OP_LW;
               3'b100:  op = OP_LBU;
               3'b101:  op = OP_LHU;
               default: op = OP_INVALID;
            endcase
         end
         OPC_OPIMM: begin
            en = 4'b1101;
            case (f3)
               3'b000: op = OP_ADDI;
               3'b010: op = OP_SLTI;
               3'b011: op = OP_SLTIU;
               3'b100: op = OP_XORI;
               3'b110: op = OP_ORI;
               3'b111: op = OP_ANDI;
               3'b001: begin
                  en    = 4'b1100;
                  shamt = instr[24:20];
                  op    = f7 == 7'b0000000 ? OP_SLLI : OP_INVALID;
               end
               default: begin
                  en    = 4'b1100;
                  shamt = instr[24:20];
                  op    = f7 == 7'b0000000 ? OP_SRLI : f7 == 7'b0100000 ? OP_SRAI : OP_INVALID;
               end
            endcase
         end
         OPC_OP: begin
            en = 4'b1110;
            if (HAS_M && f7 == 7'b0000001)
               case (f3)
                  3'b000: op = OP_MUL;
                  3'b001: op = OP_MULH;
                  3'b010: op = OP_MULHSU;
                  3'b011: op = OP_MULHU;
                  3'b100: op = OP_DIV;
                  3'b101: op = OP_DIVU;
                  3'b110: op = OP_REM;
                  3'b111: op = OP_REMU;
               endcase
            else
               case ({f7, f3})
                  10'b0000000_000: op = OP_ADD;
                  10'b0100000_000: op = OP_SUB;
                  10'b0000000_001: op = OP_SLL;
                  10'b0000000_010: op = OP_SLT;
                  10'b0000000_011: op = OP_SLTU;
                  10'b0000000_100: op = OP_XOR;
                  10'b0000000_101: op = OP_SRL;
                  10'b0100000_101: op = OP_SRA;
                  10'b0000000_110: op = OP_OR;
                  10'b0000000_111: op = OP_AND;
                  default:         op = OP_INVALID;
               endcase
         end
         OPC_MISC:
            op = f3 == 3'b000 ? OP_FENCE : f3 == 3'b001 ? OP_FENCEI : OP_INVALID;
         OPC_SYSTEM:
            op = instr == 32'h0000_0073 ? OP_ECALL : instr == 32'h0010_0073 ? OP_EBREAK : OP_INVALID;
         default: op = OP_INVALID;
      endcase
      if (op == OP_INVALID) begin
         en    = 4'b0000;
         shamt = 5'd0;
      end
   end

   assign dec = '{
      op:      op,
      rd:      en[3] ? instr[11:7]  : 5'd0,
      rs1:     en[2] ? instr[19:15] : 5'd0,
      rs2:     en[1] ? instr[24:20] : 5'd0,
      rd_en:   en[3],
      rs1_en:  en[2],
      rs2_en:  en[1],
      imm_en:  en[0],
      imm:     en[0] ? imm : 32'd0,
      shamt:   shamt,
      invalid: op == OP_INVALID
   };

endmodule

// File: rtl/idu_pipe.sv
// idu_pipe: FIFO-buffered, one-per-cycle RV32I decode stage feeding the CU (RV32M via IDU_PIPE_RV32M_EN)
module idu_pipe
   import idu_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int OP_W       = 6,
   parameter int PC_W       = 32
) (
   input  logic            soc_clk,
   input  logic            IDU_reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] out_op,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic            out_rd_en,
   output logic            out_rs1_en,
   output logic            out_rs2_en,
   output logic            out_imm_en,
   output logic [31:0]     out_imm,
   output logic [4:0]      out_shamt,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_pc_increment,
   output logic            out_invalid
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [31:0]     mem_instr [FIFO_DEPTH];
   logic [PC_W-1:0] mem_pc    [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            push, pop;
   idu_dec_t        dec, q;
   logic [PC_W-1:0] q_pc;

   assign in_ready = count != (AW+1)'(FIFO_DEPTH);
   assign push     = in_valid && in_ready;
   assign pop      = count != '0 && (!out_valid || out_ready);

   idu_decode_comb u_dec (
      .instr (mem_instr[rd_ptr]),
      .dec   (dec)
   );

   // FIFO storage; a write during flush lands in a slot the reset pointers disown
   always_ff @(posedge soc_clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

   // FIFO pointers and occupancy; flush discards everything including a same-cycle push
   always_ff @(posedge soc_clk) begin
      if (IDU_reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // decoded-instruction register; holds while the CU stalls, refills on every pop
   always_ff @(posedge soc_clk) begin
      if (IDU_reset) begin
         out_valid <= 1'b0;
         q         <= '0;
         q_pc      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (pop) begin
         out_valid <= 1'b1;
         q         <= dec;
         q_pc      <= mem_pc[rd_ptr];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_op           = OP_W'(q.op);
   assign out_rd           = q.rd;
   assign out_rs1          = q.rs1;
   assign out_rs2          = q.rs2;
   assign out_rd_en        = q.rd_en;
   assign out_rs1_en       = q.rs1_en;
   assign out_rs2_en       = q.rs2_en;
   assign out_imm_en       = q.imm_en;
   assign out_imm          = q.imm;
   assign out_shamt        = q.shamt;
   assign out_invalid      = q.invalid;
   assign out_pc           = q_pc;
   assign out_pc_increment = 32'd4;

endmodule
